// File: rtl/instr_block_loader.sv
// Block loader feeding the fetch stage: one request/grant handshake, then NUM_INSTR in-order beats.
// Optional build macro LOADER_TIMEOUT_EN adds an inter-beat timeout with a sticky err flag.
module instr_block_loader #(
  parameter int NUM_INSTR      = 16,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_gnt,
  input  logic              mem_rd_data_vld,
  input  logic [31:0]       mem_rd_data,
  output logic [31:0]       instructions_out [NUM_INSTR],
  output logic              instr_vld,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(NUM_INSTR);

  if (NUM_INSTR < 2 || (NUM_INSTR & (NUM_INSTR - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("instr_block_loader: NUM_INSTR must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     beat_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              accept_start;
  logic              beat_write;
  logic              last_beat;
  logic              timeout;

  assign accept_start = (state == IDLE) && start && !flush;
  assign beat_write   = (state == RECV) && mem_rd_data_vld && !flush;
  assign last_beat    = beat_write && (beat_cnt == CW'(NUM_INSTR - 1));

  assign mem_rd_req  = (state == REQ);
  assign mem_rd_addr = addr_q;
  assign instr_vld   = (state == DONE);
  assign busy        = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept_start) state_nxt = REQ;
      REQ:  if (mem_rd_gnt) state_nxt = RECV;
      RECV: begin
        if (timeout)        state_nxt = IDLE;
        else if (last_beat) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept_start) addr_q <= base_addr & ~ADDR_W'(NUM_INSTR - 1);
      if (flush || (state == REQ && mem_rd_gnt)) beat_cnt <= '0;
      else if (beat_write)                        beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // NOTE: the block array is reset explicitly because consumers rely on all-zero contents after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_INSTR; i++) instructions_out[i] <= '0;
    end else if (beat_write) begin
      instructions_out[beat_cnt] <= mem_rd_data;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive beat-less RECV cycle.
  assign timeout = (state == RECV) && !mem_rd_data_vld && !flush &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != RECV || mem_rd_data_vld || flush) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + 1'b1;
      if (accept_start) err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Memory must only deliver beats after a grant and before the block completes.
  a_no_stray_beats: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rd_data_vld && (state == REQ || state == DONE)));

endmodule

// File: tb/tb_instr_block_loader.sv
// Self-checking bench for instr_block_loader: transaction-level expectations, per-cycle compare, random stalls.
module tb_instr_block_loader;

  localparam int NUM = 16;
`ifdef LOADER_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        flush;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_data_vld;
  logic [31:0] mem_rd_data;
  logic [31:0] instructions_out [NUM];
  logic        instr_vld;
  logic        busy;
  logic        err;

  instr_block_loader #(.NUM_INSTR(NUM), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .flush(flush),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rd_data_vld(mem_rd_data_vld), .mem_rd_data(mem_rd_data),
    .instructions_out(instructions_out), .instr_vld(instr_vld), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cnt = 0;
  int vld_cnt = 0;
  int vld_cyc = 0;
  bit chk_en = 1'b0;

  // Expected outputs, updated by the stimulus tasks from the block-level rules.
  logic        exp_req, exp_busy, exp_vld, exp_err;
  logic [31:0] exp_addr;
  logic [31:0] exp_arr [NUM];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_rd_req && mem_rd_gnt) hs_cnt++;
      if (instr_vld) begin
        vld_cnt++;
        vld_cyc = cyc;
      end
      check("mem_rd_req", {31'b0, mem_rd_req}, {31'b0, exp_req});
      check("mem_rd_addr", mem_rd_addr, exp_addr);
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      check("instr_vld", {31'b0, instr_vld}, {31'b0, exp_vld});
      check("err", {31'b0, err}, {31'b0, exp_err});
      for (int i = 0; i < NUM; i++)
        check($sformatf("instructions_out[%0d]", i), instructions_out[i], exp_arr[i]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected below 2000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_req = 1'b0; exp_busy = 1'b0; exp_vld = 1'b0; exp_err = 1'b0; exp_addr = '0;
    for (int i = 0; i < NUM; i++) exp_arr[i] = '0;
  endtask

  // abort_kind: 0 complete, 1 flush, 2 async reset, 3 timeout. fill_kind: 0 A0000000+i, 1 random, 2 constant 5.
  task automatic load_block(input logic [31:0] base, input int gnt_delay, input int max_gap,
                            input int busy_start_beat, input int abort_after, input int abort_kind,
                            input int fill_kind);
    int beats, start_cyc, hs0, vld0, gap;
    logic [31:0] d;
    beats = (abort_kind == 0) ? NUM : abort_after;
    start = 1'b1; base_addr = base;
    start_cyc = cyc; hs0 = hs_cnt; vld0 = vld_cnt;
    step();
    start = 1'b0; base_addr = $urandom;
    exp_req = 1'b1; exp_busy = 1'b1; exp_err = 1'b0;
    exp_addr = base & ~32'(NUM - 1);
    repeat (gnt_delay) step();
    mem_rd_gnt = 1'b1;
    step();
    mem_rd_gnt = 1'b0;
    exp_req = 1'b0;
    for (int i = 0; i < beats; i++) begin
      if (i == busy_start_beat) begin
        start = 1'b1; base_addr = 32'h400;
        step();
        start = 1'b0;
      end
      gap = $urandom_range(0, max_gap);
      repeat (gap) step();
      case (fill_kind)
        0:       d = 32'hA000_0000 + 32'(i);
        1:       d = $urandom;
        default: d = 32'h5;
      endcase
      mem_rd_data_vld = 1'b1; mem_rd_data = d;
      step();
      mem_rd_data_vld = 1'b0; mem_rd_data = $urandom;
      exp_arr[i] = d;
      if (i == NUM - 1) exp_vld = 1'b1;
    end
    case (abort_kind)
      0: begin
        step();
        exp_vld = 1'b0; exp_busy = 1'b0;
        check("vld_pulses", 32'(vld_cnt - vld0), 32'd1);
        if (gnt_delay == 0 && max_gap == 0 && busy_start_beat < 0) begin
          check("lit_vld_latency", 32'(vld_cyc - start_cyc), 32'd18);
          check("lit_busy_low_cycle", 32'(cyc - start_cyc), 32'd19);
        end
      end
      1: begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_busy = 1'b0;
        step();
        check("flush_no_vld", 32'(vld_cnt - vld0), 32'd0);
      end
      2: begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy_now", {31'b0, busy}, 32'd0);
        check("rst_req_now", {31'b0, mem_rd_req}, 32'd0);
        check("rst_arr0_now", instructions_out[0], 32'd0);
        check("rst_arr2_now", instructions_out[2], 32'd0);
        model_reset();
        step();
        rst_n = 1'b1;
      end
`ifdef LOADER_TIMEOUT_EN
      3: begin
        repeat (TMO - 1) step();
        check("tmo_not_early", {31'b0, err}, 32'd0);
        step();
        exp_err = 1'b1; exp_busy = 1'b0;
        check("lit_tmo_err", {31'b0, err}, 32'd1);
        step();
        check("tmo_no_vld", 32'(vld_cnt - vld0), 32'd0);
      end
`endif
      default: ;
    endcase
    check("handshakes", 32'(hs_cnt - hs0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; flush = 1'b0;
    mem_rd_gnt = 1'b0; mem_rd_data_vld = 1'b0; mem_rd_data = '0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // Basic load with literal pins on address and contents.
    load_block(32'h123, 0, 0, -1, 0, 0, 0);
    check("lit_addr", mem_rd_addr, 32'h120);
    check("lit_arr15", instructions_out[15], 32'hA000_000F);

    // Stalled grant and gapped beats.
    load_block(32'h0000_BEEF, 5, 3, -1, 0, 0, 1);

    // Start while busy is ignored.
    load_block(32'h0000_2000, 1, 1, 4, 0, 0, 1);
    check("lit_addr_busy_start", mem_rd_addr, 32'h2000);

    // Flush after 7 beats, then a constant-fill block.
    load_block(32'h0000_0780, 0, 2, -1, 7, 1, 1);
    load_block(32'h40, 0, 1, -1, 0, 0, 2);
    check("lit_flush_arr0", instructions_out[0], 32'h5);
    check("lit_flush_arr6", instructions_out[6], 32'h5);

    // Flush and start together in IDLE: flush wins.
    start = 1'b1; flush = 1'b1; base_addr = 32'h9990;
    step();
    start = 1'b0; flush = 1'b0;
    step();

    // Flush while waiting for the grant.
    start = 1'b1; base_addr = 32'h3333;
    step();
    start = 1'b0;
    exp_req = 1'b1; exp_busy = 1'b1; exp_addr = 32'h3330;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_req = 1'b0; exp_busy = 1'b0;
    step();

    // Reset after 3 beats, then a fresh load.
    load_block(32'h0000_5550, 2, 1, -1, 3, 2, 1);
    load_block(32'h0000_6661, 0, 0, -1, 0, 0, 0);

`ifdef LOADER_TIMEOUT_EN
    load_block(32'h0000_7000, 1, 0, -1, 4, 3, 1);
    load_block(32'h0000_7100, 0, 1, -1, 0, 0, 1);
`endif

    // Randomized blocks, occasionally flushed.
    for (int n = 0; n < 8; n++) begin
      if (n == 5) load_block($urandom, $urandom_range(0, 4), 3, -1, $urandom_range(1, NUM - 1), 1, 1);
      else        load_block($urandom, $urandom_range(0, 4), 3, -1, 0, 0, 1);
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
